mul_job_sched: RTL and testbench

Job scheduler for the shared register-file / multiplier / RAM datapath. It accepts multiply jobs from two requesters, each job being two operand addresses and one RAM destination. It arbitrates round-robin and runs each granted job through load-A, load-B, multiply and RAM-write. It reports completion with a done pulse tagged by requester ID.

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/rr_arb2.sv | 28 ++
 rtl/mul_job_sched.sv | 141 ++++++++++++++
 tb/tb_mul_job_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared encodings for the multiply job scheduler: FSM state codes and the
// destination/source mux patterns driven during the two operand loads.
package mul_sched_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD_A = 4'd1,
      ST_LOAD_B = 4'd2,
      ST_MUL    = 4'd3,
      ST_WRITE  = 4'd4,
      ST_DONE   = 4'd5,
      ST_READ   = 4'd6
   } state_t;

   // Bit order is {DA, SA, SB}
   localparam logic [2:0] LOAD_A_SEL = 3'b001;
   localparam logic [2:0] LOAD_B_SEL = 3'b101;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant moves only when a grant is taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_id
);

   logic last_grant;

   always_comb begin
      // On contention the requester that did not win last time goes next
      grant_id = (valid == 2'b11) ? ~last_grant : valid[1];
      grant    = 2'b00;
      if (valid != 2'b00)
         grant = grant_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (advance)
         last_grant <= grant_id;
   end

endmodule

// File: rtl/mul_job_sched.sv
// Multiply job scheduler: round-robin accept, then load-A, load-B, multiply,
// RAM write, done. Define MUL_SCHED_READBACK_EN to add a RAM read-back state.
module mul_job_sched
   import mul_sched_pkg::*;
#(
   parameter int ADR_W   = 3,
   parameter int RAM_AW  = 3,
   parameter int MUL_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADR_W-1:0]  req0_adr1,
   input  logic [ADR_W-1:0]  req0_adr2,
   input  logic [RAM_AW-1:0] req0_dst,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADR_W-1:0]  req1_adr1,
   input  logic [ADR_W-1:0]  req1_adr2,
   input  logic [RAM_AW-1:0] req1_dst,
   output logic              req1_ready,
   output logic              rf_we,
   output logic [ADR_W-1:0]  rf_adr,
   output logic              DA,
   output logic              SA,
   output logic              SB,
   output logic              ram_we,
   output logic              ram_re,
   output logic [RAM_AW-1:0] ram_adr,
   output logic              done_valid,
   output logic              done_id,
   output logic              busy,
   output logic [3:0]        st_out
);

   localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

   state_t            state, state_nxt;
   logic [3:0]        mul_cnt, mul_cnt_nxt;
   logic [ADR_W-1:0]  job_adr1, job_adr2;
   logic [RAM_AW-1:0] job_dst;
   logic              job_id;
   logic [1:0]        grant;
   logic              grant_id;
   logic              advance;

   assign advance = (state == ST_IDLE) && (req0_valid || req1_valid);

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .valid    ({req1_valid, req0_valid}),
      .advance  (advance),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req0_ready = (state == ST_IDLE) && grant[0];
   assign req1_ready = (state == ST_IDLE) && grant[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mul_cnt  <= '0;
         job_adr1 <= '0;
         job_adr2 <= '0;
         job_dst  <= '0;
         job_id   <= 1'b0;
      end else begin
         state   <= state_nxt;
         mul_cnt <= mul_cnt_nxt;
         if (advance) begin
            job_adr1 <= grant_id ? req1_adr1 : req0_adr1;
            job_adr2 <= grant_id ? req1_adr2 : req0_adr2;
            job_dst  <= grant_id ? req1_dst  : req0_dst;
            job_id   <= grant_id;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      mul_cnt_nxt  = '0;
      rf_we        = 1'b0;
      rf_adr       = '0;
      {DA, SA, SB} = 3'b000;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      ram_adr      = '0;
      done_valid   = 1'b0;
      done_id      = 1'b0;
      case (state)
         ST_IDLE: if (advance) state_nxt = ST_LOAD_A;
         ST_LOAD_A: begin
            rf_we        = 1'b1;
            rf_adr       = job_adr1;
            {DA, SA, SB} = LOAD_A_SEL;
            state_nxt    = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            rf_we        = 1'b1;
            rf_adr       = job_adr2;
            {DA, SA, SB} = LOAD_B_SEL;
            state_nxt    = ST_MUL;
         end
         ST_MUL: begin
            // Counter is 0 on entry, so the state lasts exactly MUL_LAT cycles
            if (mul_cnt == MUL_LAST)
               state_nxt = ST_WRITE;
            else
               mul_cnt_nxt = mul_cnt + 4'd1;
         end
         ST_WRITE: begin
            ram_we  = 1'b1;
            ram_adr = job_dst;
`ifdef MUL_SCHED_READBACK_EN
            state_nxt = ST_READ;
`else
            state_nxt = ST_DONE;
`endif
         end
`ifdef MUL_SCHED_READBACK_EN
         ST_READ: begin
            ram_re    = 1'b1;
            ram_adr   = job_dst;
            state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            done_valid = 1'b1;
            done_id    = job_id;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy   = (state != ST_IDLE);
   assign st_out = state;

endmodule

// File: tb/tb_mul_job_sched.sv
// Bench for mul_job_sched: two instances (MUL_LAT 1 and 3) checked every cycle
// against a timeline model counting cycles since each job's acceptance.
module tb_mul_job_sched;

`ifdef MUL_SCHED_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       v0, v1;
   logic [2:0] a10, a20, d0, a11, a21, d1;

   logic [1:0] rdy0, rdy1, rf_we, da, sa, sb, ram_we, ram_re, done_valid, done_id, busy;
   logic [2:0] rf_adr [2];
   logic [2:0] ram_adr [2];
   logic [3:0] st [2];

   int errors = 0;
   int checks = 0;
   bit auto_drop = 1'b0;
   bit done_q [$];

   // Reference model: per instance, job active flag and cycles since acceptance
   bit         m_busy [2];
   int         m_k [2];
   bit         m_id [2];
   bit         m_last [2];
   logic [2:0] m_a1 [2], m_a2 [2], m_dst [2];
   int         lat [2] = '{1, 3};

   mul_job_sched #(.ADR_W(3), .RAM_AW(3), .MUL_LAT(1)) dut_a (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_adr1(a10), .req0_adr2(a20), .req0_dst(d0), .req0_ready(rdy0[0]),
      .req1_valid(v1), .req1_adr1(a11), .req1_adr2(a21), .req1_dst(d1), .req1_ready(rdy1[0]),
      .rf_we(rf_we[0]), .rf_adr(rf_adr[0]), .DA(da[0]), .SA(sa[0]), .SB(sb[0]),
      .ram_we(ram_we[0]), .ram_re(ram_re[0]), .ram_adr(ram_adr[0]),
      .done_valid(done_valid[0]), .done_id(done_id[0]), .busy(busy[0]), .st_out(st[0]));

   mul_job_sched #(.ADR_W(3), .RAM_AW(3), .MUL_LAT(3)) dut_b (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_adr1(a10), .req0_adr2(a20), .req0_dst(d0), .req0_ready(rdy0[1]),
      .req1_valid(v1), .req1_adr1(a11), .req1_adr2(a21), .req1_dst(d1), .req1_ready(rdy1[1]),
      .rf_we(rf_we[1]), .rf_adr(rf_adr[1]), .DA(da[1]), .SA(sa[1]), .SB(sb[1]),
      .ram_we(ram_we[1]), .ram_re(ram_re[1]), .ram_adr(ram_adr[1]),
      .done_valid(done_valid[1]), .done_id(done_id[1]), .busy(busy[1]), .st_out(st[1]));

   task automatic chk(input int d, input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int         k, l, done_k;
         logic [3:0] e_st;
         logic       e_r0, e_r1, e_rfwe, e_we, e_re, e_dv, e_did, g;
         logic [2:0] e_rfadr, e_sel, e_radr;
         k = m_k[d]; l = lat[d]; done_k = 4 + l + RB;
         e_st = 4'd0; e_r0 = 0; e_r1 = 0; e_rfwe = 0; e_we = 0; e_re = 0; e_dv = 0; e_did = 0;
         e_rfadr = 0; e_sel = 0; e_radr = 0;
         g = (v0 && v1) ? ~m_last[d] : v1;
         if (!m_busy[d]) begin
            e_r0 = (v0 || v1) && !g;
            e_r1 = (v0 || v1) && g;
         end else if (k == 1) begin
            e_st = 4'd1; e_rfwe = 1; e_rfadr = m_a1[d]; e_sel = 3'b001;
         end else if (k == 2) begin
            e_st = 4'd2; e_rfwe = 1; e_rfadr = m_a2[d]; e_sel = 3'b101;
         end else if (k <= 2 + l) begin
            e_st = 4'd3;
         end else if (k == 3 + l) begin
            e_st = 4'd4; e_we = 1; e_radr = m_dst[d];
         end else if (k == done_k) begin
            e_st = 4'd5; e_dv = 1; e_did = m_id[d];
         end else begin
            e_st = 4'd6; e_re = 1; e_radr = m_dst[d];
         end
         chk(d, "st_out", 8'(st[d]), 8'(e_st));
         chk(d, "ready", 8'({rdy1[d], rdy0[d]}), 8'({e_r1, e_r0}));
         chk(d, "rf", 8'({rf_we[d], rf_adr[d]}), 8'({e_rfwe, e_rfadr}));
         chk(d, "mux", 8'({da[d], sa[d], sb[d]}), 8'(e_sel));
         chk(d, "ram", 8'({ram_we[d], ram_re[d], ram_adr[d]}), 8'({e_we, e_re, e_radr}));
         chk(d, "done", 8'({done_valid[d], done_id[d]}), 8'({e_dv, e_did}));
         chk(d, "busy", 8'(busy[d]), 8'(m_busy[d]));
         if (d == 0 && done_valid[0]) done_q.push_back(done_id[0]);
         if (reset) begin
            m_busy[d] = 0; m_k[d] = 0; m_last[d] = 1;
         end else if (!m_busy[d]) begin
            if (v0 || v1) begin
               m_busy[d] = 1; m_k[d] = 1; m_id[d] = g; m_last[d] = g;
               m_a1[d] = g ? a11 : a10; m_a2[d] = g ? a21 : a20; m_dst[d] = g ? d1 : d0;
            end
         end else if (k == done_k) begin
            m_busy[d] = 0; m_k[d] = 0;
         end else begin
            m_k[d] = k + 1;
         end
      end
      begin
         logic drop0, drop1;
         drop0 = auto_drop && rdy0[0];
         drop1 = auto_drop && rdy1[0];
         @(posedge clk);
         #1;
         if (drop0) v0 = 0;
         if (drop1) v1 = 0;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      for (int i = 0; i < n; i++) step();
      reset = 0;
   endtask

   initial begin
      reset = 1; v0 = 0; v1 = 0;
      a10 = 0; a20 = 0; d0 = 0; a11 = 0; a21 = 0; d1 = 0;
      for (int d = 0; d < 2; d++) begin m_busy[d] = 0; m_k[d] = 0; m_last[d] = 1; m_id[d] = 0; end
      @(posedge clk); #1;
      do_reset(2);

      // Basic job on requester 0
      auto_drop = 1;
      v0 = 1; a10 = 3; a20 = 5; d0 = 2;
      for (int i = 0; i < 12; i++) step();

      // Simultaneous requests right after reset: 0 then 1
      do_reset(1);
      done_q.delete();
      v0 = 1; a10 = 1; a20 = 2; d0 = 3;
      v1 = 1; a11 = 4; a21 = 6; d1 = 7;
      for (int i = 0; i < 24; i++) step();
      chk(0, "simul_count", 8'(done_q.size()), 8'd2);
      if (done_q.size() == 2) begin
         chk(0, "simul_id0", 8'(done_q[0]), 8'd0);
         chk(0, "simul_id1", 8'(done_q[1]), 8'd1);
      end

      // Continuous contention: both held valid for four jobs
      auto_drop = 0;
      do_reset(1);
      done_q.delete();
      v0 = 1; v1 = 1;
      for (int i = 0; i < 24; i++) step();
      v0 = 0; v1 = 0;
      for (int i = 0; i < 10; i++) step();
      chk(0, "contend_count", 8'(done_q.size()), 8'd4);
      for (int i = 0; i < 4 && i < done_q.size(); i++)
         chk(0, "contend_order", 8'(done_q[i]), 8'(i % 2));

      // Reset while instance A sits in MUL
      auto_drop = 1;
      v1 = 1; a11 = 2; a21 = 3; d1 = 5;
      begin
         int n;
         n = 0;
         while (st[0] !== 4'd3 && n < 20) begin step(); n++; end
         chk(0, "reach_mul", 8'(st[0]), 8'd3);
      end
      v1 = 0;
      do_reset(1);
      for (int i = 0; i < 10; i++) step();

      // Randomized traffic with occasional resets
      auto_drop = 0;
      for (int i = 0; i < 400; i++) begin
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         a10 = 3'($urandom); a20 = 3'($urandom); d0 = 3'($urandom);
         a11 = 3'($urandom); a21 = 3'($urandom); d1 = 3'($urandom);
         reset = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 0; v0 = 0; v1 = 0;
      for (int i = 0; i < 12; i++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
